alu_bit_serializer: RTL and testbench

Front-end sequencer for the 1-bit `aluOperations` slice. It accepts a WIDTH-bit operand pair and 3-bit opcode through a valid/ready handshake. It then presents one bit pair per clock (LSB first) to the slice's A/B/S inputs and collects the combinational F return into a WIDTH-bit result, which it holds under a valid/ready handshake. This lets the single-bit ALU process multi-bit words without replicating it.

---
 rtl/alu_bit_serializer.sv | 87 ++++++++
 tb/tb_alu_bit_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serializer.sv
// Bit-serial front end for a 1-bit ALU slice: accepts a word-wide operand pair,
// feeds the slice one bit pair per clock (LSB first) and assembles its F output.
`timescale 1ns/1ps

module alu_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  output logic             alu_a,
  output logic             alu_b,
  output logic [2:0]       alu_s,
  input  logic             alu_f,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid)  state_next = SHIFT;
      SHIFT:   if (cnt == LAST)  state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Operands shift right so the slice always sees bit 0; F lands at result[cnt].
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= 3'b000;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            op_q   <= op_in;
            cnt    <= '0;
            result <= '0;
          end
        end
        SHIFT: begin
          result <= result | (WIDTH'(alu_f) << cnt);
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // start_ready also drops while rst is high so a request can never slip past reset.
  assign start_ready  = (state == IDLE) && !rst;
  assign alu_a        = (state == SHIFT) && a_sh[0];
  assign alu_b        = (state == SHIFT) && b_sh[0];
  assign alu_s        = (state == SHIFT) ? op_q : 3'b000;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_bit_serializer.sv
// Bench for alu_bit_serializer: behavioural 1-bit slice stub, word-level reference
// model, directed scenarios followed by randomized jobs.
`timescale 1ns/1ps

module tb_alu_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [2:0] op_in = '0;
  logic       alu_a, alu_b, alu_f;
  logic [2:0] alu_s;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       busy;

  logic       start_valid1 = 1'b0;
  logic       start_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic [2:0] op1 = '0;
  logic       alu_a1, alu_b1, alu_f1;
  logic [2:0] alu_s1;
  logic [0:0] result1;
  logic       result_valid1;
  logic       result_ready1 = 1'b0;
  logic       busy1;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int xfer_q[$];

  always #5 clk = ~clk;

  alu_bit_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .alu_f(alu_f), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  alu_bit_serializer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(start_valid1), .start_ready(start_ready1),
    .a_in(a1), .b_in(b1), .op_in(op1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_s(alu_s1), .alu_f(alu_f1), .result(result1), .result_valid(result_valid1),
    .result_ready(result_ready1), .busy(busy1)
  );

  function automatic logic slice_f(input logic a, input logic b, input logic [2:0] s);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_f  = slice_f(alu_a, alu_b, alu_s);
  assign alu_f1 = slice_f(alu_a1, alu_b1, alu_s1);

  // Transfer log: the handshake is stable mid-cycle, so sample it on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start_valid && start_ready) xfer_q.push_back(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                input int hold, input bit noisy);
    logic [7:0] exp;
    exp = model(a, b, op);
    start_valid  = 1'b1;
    a_in         = a;
    b_in         = b;
    op_in        = op;
    result_ready = 1'b0;
    check_output("start_ready_idle", start_ready, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      start_valid = noisy;
      if (noisy) begin
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        op_in = 3'($urandom);
      end
      check_output("shift_busy", busy, 1);
      check_output("shift_no_valid", result_valid, 0);
      check_output("shift_not_ready", start_ready, 0);
      check_output("shift_alu_s", alu_s, op);
      check_output("shift_alu_a", alu_a, a[k]);
      check_output("shift_alu_b", alu_b, b[k]);
      tick();
    end
    start_valid = 1'b0;
    for (int d = 0; d < hold; d++) begin
      check_output("done_valid", result_valid, 1);
      check_output("done_busy", busy, 1);
      check_output("done_result", result, exp);
      tick();
    end
    result_ready = 1'b1;
    check_output("done_valid_final", result_valid, 1);
    check_output("done_result_final", result, exp);
    tick();
    result_ready = 1'b0;
    check_output("idle_valid", result_valid, 0);
    check_output("idle_busy", busy, 0);
    check_output("idle_ready", start_ready, 1);
    check_output("idle_result_kept", result, exp);
    tick();
    check_output("idle_no_second_job", busy, 0);
  endtask

  initial begin
    int q0;
    int gap;
    logic [2:0] ops [3];
    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b011;

    #1;
    check_output("reset_ready_low", start_ready, 0);
    tick();
    tick();
    check_output("reset_result", result, 0);
    check_output("reset_valid", result_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_alu_a", alu_a, 0);
    check_output("reset_alu_s", alu_s, 0);
    rst = 1'b0;
    #1;
    check_output("reset_release_ready", start_ready, 1);

    apply_stimulus(8'hA5, 8'h0F, 3'b011, 0, 1'b0);
    apply_stimulus(8'hF0, 8'h3C, 3'b000, 5, 1'b0);
    apply_stimulus(8'h01, 8'h80, 3'b001, 0, 1'b1);

    // Reset in the middle of a job
    start_valid = 1'b1;
    a_in  = 8'hC3;
    b_in  = 8'h5A;
    op_in = 3'b011;
    tick();
    start_valid = 1'b0;
    repeat (3) tick();
    check_output("midop_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_output("midop_result", result, 0);
    check_output("midop_valid", result_valid, 0);
    check_output("midop_busy_clr", busy, 0);
    check_output("midop_alu_a", alu_a, 0);
    check_output("midop_alu_b", alu_b, 0);
    check_output("midop_alu_s", alu_s, 0);
    check_output("midop_ready", start_ready, 1);
    apply_stimulus(8'h55, 8'h55, 3'b011, 0, 1'b0);

    // Reset and request together
    rst = 1'b1;
    start_valid = 1'b1;
    a_in = 8'hFF;
    #1;
    check_output("rst_blocks_ready", start_ready, 0);
    tick();
    rst = 1'b0;
    start_valid = 1'b0;
    check_output("rst_wins_busy", busy, 0);
    tick();
    check_output("rst_wins_busy2", busy, 0);

    // Back-to-back with start_valid held
    q0 = xfer_q.size();
    start_valid  = 1'b1;
    a_in         = 8'h3C;
    b_in         = 8'hA5;
    op_in        = 3'b011;
    result_ready = 1'b1;
    tick();
    repeat (8) tick();
    check_output("b2b_valid1", result_valid, 1);
    check_output("b2b_result1", result, model(8'h3C, 8'hA5, 3'b011));
    check_output("b2b_done_not_ready", start_ready, 0);
    a_in  = 8'h0F;
    b_in  = 8'hF1;
    op_in = 3'b000;
    tick();
    check_output("b2b_idle_ready", start_ready, 1);
    tick();
    check_output("b2b_busy2", busy, 1);
    repeat (8) tick();
    check_output("b2b_valid2", result_valid, 1);
    check_output("b2b_result2", result, model(8'h0F, 8'hF1, 3'b000));
    start_valid = 1'b0;
    tick();
    result_ready = 1'b0;
    check_output("b2b_xfer_count", xfer_q.size() - q0, 2);
    gap = (xfer_q.size() >= q0 + 2) ? xfer_q[q0 + 1] - xfer_q[q0] : -1;
    check_output("b2b_xfer_gap", gap, 10);

    // WIDTH=1 instance
    start_valid1  = 1'b1;
    a1            = 1'b1;
    b1            = 1'b0;
    op1           = 3'b001;
    result_ready1 = 1'b1;
    tick();
    start_valid1 = 1'b0;
    check_output("w1_busy", busy1, 1);
    check_output("w1_alu_a", alu_a1, 1);
    check_output("w1_alu_b", alu_b1, 0);
    check_output("w1_alu_s", alu_s1, 3'b001);
    check_output("w1_not_valid", result_valid1, 0);
    tick();
    check_output("w1_valid", result_valid1, 1);
    check_output("w1_result", result1, 1);
    tick();
    check_output("w1_idle_valid", result_valid1, 0);
    check_output("w1_idle_busy", busy1, 0);
    check_output("w1_result_kept", result1, 1);
    result_ready1 = 1'b0;

    for (int j = 0; j < 20; j++) begin
      apply_stimulus(8'($urandom), 8'($urandom), ops[$urandom_range(0, 2)],
                     int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
